// File: rtl/mmu_req_arbiter_pkg.sv
// rtl/mmu_req_arbiter_pkg.sv - shared constants and types for the MMU request arbiter
package mmu_req_arbiter_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CHECK = 2'd1;
  localparam logic [1:0] S_TLBW  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic [2:0] EXC_NONE = 3'd0;
  localparam logic [2:0] EXC_ADE  = 3'd1;
  localparam logic [2:0] EXC_TLBR = 3'd2;
  localparam logic [2:0] EXC_PI   = 3'd3;
  localparam logic [2:0] EXC_PPI  = 3'd4;
  localparam logic [2:0] EXC_PME  = 3'd5;

  localparam int CRMD_PLV_LO  = 0;
  localparam int CRMD_DA      = 3;
  localparam int CRMD_PG      = 4;
  localparam int CRMD_DATF_LO = 5;
  localparam int CRMD_DATM_LO = 7;

  localparam int DMW_MAT_LO  = 4;
  localparam int DMW_PSEG_LO = 25;
  localparam int DMW_VSEG_LO = 29;

  localparam logic [5:0] PS_4K = 6'd12;
  localparam logic [5:0] PS_2M = 6'd21;

  typedef struct packed {
    logic [31:0] paddr;
    logic [2:0]  exc;
    logic [1:0]  mat;
  } xlate_res_t;

  function automatic logic [31:0] dmw_remap(input logic [31:0] dmw, input logic [31:0] va);
    return {dmw[DMW_PSEG_LO+2:DMW_PSEG_LO], va[28:0]};
  endfunction

endpackage

// File: rtl/mmu_req_arbiter_if.sv
// rtl/mmu_req_arbiter_if.sv - fetch/memory request and response bus of the MMU arbiter
interface mmu_req_arbiter_if;
  logic        inst_req_valid;
  logic        inst_req_ready;
  logic [31:0] inst_vaddr;
  logic        inst_resp_valid;
  logic        inst_resp_ready;
  logic        data_req_valid;
  logic        data_req_ready;
  logic [31:0] data_vaddr;
  logic        data_is_store;
  logic        data_resp_valid;
  logic        data_resp_ready;
  logic [31:0] resp_paddr;
  logic [2:0]  resp_exc;
  logic [1:0]  resp_mat;

  modport master (
    output inst_req_valid, inst_vaddr, inst_resp_ready,
    output data_req_valid, data_vaddr, data_is_store, data_resp_ready,
    input  inst_req_ready, inst_resp_valid, data_req_ready, data_resp_valid,
    input  resp_paddr, resp_exc, resp_mat
  );

  modport slave (
    input  inst_req_valid, inst_vaddr, inst_resp_ready,
    input  data_req_valid, data_vaddr, data_is_store, data_resp_ready,
    output inst_req_ready, inst_resp_valid, data_req_ready, data_resp_valid,
    output resp_paddr, resp_exc, resp_mat
  );
endinterface

// File: rtl/mmu_req_arbiter_addr_dmw_check.sv
// rtl/mmu_req_arbiter_addr_dmw_check.sv - direct-mode and DMW window match on a latched request
module mmu_req_arbiter_addr_dmw_check
  import mmu_req_arbiter_pkg::*;
(
  input  logic [31:0] vaddr,
  input  logic        is_inst,
  input  logic [31:0] crmd,
  input  logic [31:0] dmw0,
  input  logic [31:0] dmw1,
  output logic        direct,
  output logic        dmw0_hit,
  output logic        dmw1_hit,
  output logic [31:0] paddr,
  output logic [1:0]  mat
);

  logic [1:0] plv;
  logic [3:0] dmw0_plv_en;
  logic [3:0] dmw1_plv_en;
  logic       unused_bits;

  assign plv         = crmd[CRMD_PLV_LO+1:CRMD_PLV_LO];
  assign dmw0_plv_en = dmw0[3:0];
  assign dmw1_plv_en = dmw1[3:0];

  // DA=1/PG=1 and DA=0/PG=0 are both treated as mapped translation.
  assign direct   = crmd[CRMD_DA] & ~crmd[CRMD_PG];
  assign dmw0_hit = ~direct & dmw0_plv_en[plv]
                  & (vaddr[31:29] == dmw0[DMW_VSEG_LO+2:DMW_VSEG_LO]);
  assign dmw1_hit = ~direct & ~dmw0_hit & dmw1_plv_en[plv]
                  & (vaddr[31:29] == dmw1[DMW_VSEG_LO+2:DMW_VSEG_LO]);

  always_comb begin
    paddr = vaddr;
    mat   = is_inst ? crmd[CRMD_DATF_LO+1:CRMD_DATF_LO] : crmd[CRMD_DATM_LO+1:CRMD_DATM_LO];
    if (dmw0_hit) begin
      paddr = dmw_remap(dmw0, vaddr);
      mat   = dmw0[DMW_MAT_LO+1:DMW_MAT_LO];
    end else if (dmw1_hit) begin
      paddr = dmw_remap(dmw1, vaddr);
      mat   = dmw1[DMW_MAT_LO+1:DMW_MAT_LO];
    end
  end

  assign unused_bits = ^{crmd[31:9], crmd[2], dmw0[28], dmw0[24:6], dmw1[28], dmw1[24:6]};

endmodule

// File: rtl/mmu_req_arbiter.sv
// rtl/mmu_req_arbiter.sv - shares one translation path and TLB search port between fetch and memory
module mmu_req_arbiter
  import mmu_req_arbiter_pkg::*;
#(
  parameter int ASID_W  = 10,
  parameter int PPN_W   = 20,
  parameter bit RR_INIT = 1'b1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush,
  mmu_req_arbiter_if.slave  bus,
  input  logic [31:0]       csr_crmd,
  input  logic [31:0]       csr_dmw0,
  input  logic [31:0]       csr_dmw1,
  input  logic [ASID_W-1:0] csr_asid,
  output logic [18:0]       s_vppn,
  output logic              s_va_bit12,
  output logic [ASID_W-1:0] s_asid,
  input  logic              s_found,
  input  logic              s_v,
  input  logic              s_d,
  input  logic [PPN_W-1:0]  s_ppn,
  input  logic [5:0]        s_ps,
  input  logic [1:0]        s_plv,
  input  logic [1:0]        s_mat
);

  logic [1:0]        state;
  logic              rr;
  logic [31:0]       lat_vaddr;
  logic              lat_store;
  logic              lat_is_data;
  logic [31:0]       lat_crmd;
  logic [31:0]       lat_dmw0;
  logic [31:0]       lat_dmw1;
  logic [ASID_W-1:0] lat_asid;

  logic [31:0]       resp_paddr_q;
  logic [2:0]        resp_exc_q;
  logic [1:0]        resp_mat_q;
  logic              inst_resp_valid_q;
  logic              data_resp_valid_q;

  logic              can_grant;
  logic              tie;
  logic              grant_inst;
  logic              grant_data;
  logic              resp_ack;

  logic              chk_direct;
  logic              chk_dmw0_hit;
  logic              chk_dmw1_hit;
  logic [31:0]       chk_paddr;
  logic [1:0]        chk_mat;
  logic              chk_done;
  xlate_res_t        chk_res;
  xlate_res_t        tlb_res;

  // rr=1 means data wins the next tie; it only moves when both sides contend.
  assign can_grant  = resetn && !flush && (state == S_IDLE);
  assign tie        = bus.inst_req_valid && bus.data_req_valid;
  assign grant_data = can_grant && bus.data_req_valid && (!bus.inst_req_valid || rr);
  assign grant_inst = can_grant && bus.inst_req_valid && (!bus.data_req_valid || !rr);

  assign bus.inst_req_ready  = grant_inst;
  assign bus.data_req_ready  = grant_data;
  assign bus.inst_resp_valid = inst_resp_valid_q;
  assign bus.data_resp_valid = data_resp_valid_q;
  assign bus.resp_paddr      = resp_paddr_q;
  assign bus.resp_exc        = resp_exc_q;
  assign bus.resp_mat        = resp_mat_q;

  assign resp_ack = lat_is_data ? bus.data_resp_ready : bus.inst_resp_ready;

  assign s_vppn     = lat_vaddr[31:13];
  assign s_va_bit12 = lat_vaddr[12];
  assign s_asid     = lat_asid;

  mmu_req_arbiter_addr_dmw_check u_addr_dmw_check (
    .vaddr    (lat_vaddr),
    .is_inst  (!lat_is_data),
    .crmd     (lat_crmd),
    .dmw0     (lat_dmw0),
    .dmw1     (lat_dmw1),
    .direct   (chk_direct),
    .dmw0_hit (chk_dmw0_hit),
    .dmw1_hit (chk_dmw1_hit),
    .paddr    (chk_paddr),
    .mat      (chk_mat)
  );

  always_comb begin
    chk_done = chk_direct | chk_dmw0_hit | chk_dmw1_hit;
    chk_res  = '{paddr: chk_paddr, exc: EXC_NONE, mat: chk_mat};
    if (!chk_done && lat_vaddr[31] && (lat_crmd[CRMD_PLV_LO+1:CRMD_PLV_LO] == 2'd3)) begin
      chk_done = 1'b1;
      chk_res  = '{paddr: lat_vaddr, exc: EXC_ADE, mat: 2'd0};
    end
  end

  // TLB exceptions report paddr=0 and mat=0.
  always_comb begin
    tlb_res = '{paddr: 32'd0, exc: EXC_NONE, mat: 2'd0};
    if (!s_found) begin
      tlb_res.exc = EXC_TLBR;
    end else if (!s_v) begin
      tlb_res.exc = EXC_PI;
    end else if (lat_crmd[CRMD_PLV_LO+1:CRMD_PLV_LO] > s_plv) begin
      tlb_res.exc = EXC_PPI;
    end else if (lat_store && !s_d) begin
      tlb_res.exc = EXC_PME;
    end else begin
      tlb_res.mat   = s_mat;
      tlb_res.paddr = (s_ps == PS_2M) ? 32'({s_ppn[PPN_W-1:9], lat_vaddr[20:0]})
                                      : 32'({s_ppn, lat_vaddr[11:0]});
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state             <= S_IDLE;
      rr                <= RR_INIT;
      lat_vaddr         <= '0;
      lat_store         <= 1'b0;
      lat_is_data       <= 1'b0;
      lat_crmd          <= '0;
      lat_dmw0          <= '0;
      lat_dmw1          <= '0;
      lat_asid          <= '0;
      resp_paddr_q      <= '0;
      resp_exc_q        <= EXC_NONE;
      resp_mat_q        <= '0;
      inst_resp_valid_q <= 1'b0;
      data_resp_valid_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_inst || grant_data) begin
            lat_vaddr   <= grant_data ? bus.data_vaddr : bus.inst_vaddr;
            lat_store   <= grant_data && bus.data_is_store;
            lat_is_data <= grant_data;
            lat_crmd    <= csr_crmd;
            lat_dmw0    <= csr_dmw0;
            lat_dmw1    <= csr_dmw1;
            lat_asid    <= csr_asid;
            if (tie) rr <= ~rr;
            state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (flush) begin
            state <= S_IDLE;
          end else if (chk_done) begin
            resp_paddr_q      <= chk_res.paddr;
            resp_exc_q        <= chk_res.exc;
            resp_mat_q        <= chk_res.mat;
            inst_resp_valid_q <= !lat_is_data;
            data_resp_valid_q <= lat_is_data;
            state             <= S_RESP;
          end else begin
            state <= S_TLBW;
          end
        end
        S_TLBW: begin
          if (flush) begin
            state <= S_IDLE;
          end else begin
            resp_paddr_q      <= tlb_res.paddr;
            resp_exc_q        <= tlb_res.exc;
            resp_mat_q        <= tlb_res.mat;
            inst_resp_valid_q <= !lat_is_data;
            data_resp_valid_q <= lat_is_data;
            state             <= S_RESP;
          end
        end
        default: begin
          if (flush || resp_ack) begin
            inst_resp_valid_q <= 1'b0;
            data_resp_valid_q <= 1'b0;
            state             <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule
